// File: rtl/dvi_tmds_encoder_if.sv
// Pixel-side link of one TMDS lane: colour/control in, symbol out.
// master: pixel source/timing drives data, de, c0, c1 and reads tmds.
// slave: encoder reads data, de, c0, c1 and drives tmds.
interface dvi_tmds_encoder_if;
   logic [7:0] data;
   logic       de;
   logic       c0;
   logic       c1;
   logic [9:0] tmds;

   modport master (
      output data, de, c0, c1,
      input  tmds
   );

   modport slave (
      input  data, de, c0, c1,
      output tmds
   );
endinterface

// File: rtl/dvi_tmds_encoder.sv
// DVI TMDS 8b/10b lane encoder: transition minimisation, then DC balance.
// pixel_clk/reset: clock and async active-high reset.
// link (slave): data/de/c0/c1 in, tmds out (bit 0 sent first).
// REGISTER_INPUTS=1 adds one input register (latency 3 instead of 2).
module dvi_tmds_encoder #(
   parameter bit REGISTER_INPUTS = 1'b0
) (
   input logic              pixel_clk,
   input logic              reset,
   dvi_tmds_encoder_if.slave link
);

   localparam logic [9:0] TOK_00 = 10'h354;
   localparam logic [9:0] TOK_01 = 10'h0AB;
   localparam logic [9:0] TOK_10 = 10'h154;
   localparam logic [9:0] TOK_11 = 10'h2AB;

   function automatic logic [3:0] ones8(
      input logic [7:0] v
   );
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++)
         n = n + {3'b000, v[i]};
      return n;
   endfunction

   // optional input register
   logic [7:0] in_data;
   logic       in_de;
   logic       in_c0;
   logic       in_c1;

   if (REGISTER_INPUTS) begin : g_inreg
      always_ff @(posedge pixel_clk or posedge reset) begin
         if (reset) begin
            in_data <= 8'h00;
            in_de   <= 1'b0;
            in_c0   <= 1'b0;
            in_c1   <= 1'b0;
         end else begin
            in_data <= link.data;
            in_de   <= link.de;
            in_c0   <= link.c0;
            in_c1   <= link.c1;
         end
      end
   end else begin : g_noreg
      assign in_data = link.data;
      assign in_de   = link.de;
      assign in_c0   = link.c0;
      assign in_c1   = link.c1;
   end

   // stage 1: transition minimisation
   logic [8:0] qm_d;
   logic [3:0] n1q_d;

   always_comb begin
      logic [3:0] n1;
      logic       use_xnor;
      logic [8:0] q;
      n1 = ones8(in_data);
      use_xnor = (n1 > 4'd4) ||
                 ((n1 == 4'd4) && !in_data[0]);
      q = 9'h000;
      q[0] = in_data[0];
      for (int i = 1; i < 8; i++) begin
         if (use_xnor)
            q[i] = ~(q[i-1] ^ in_data[i]);
         else
            q[i] = q[i-1] ^ in_data[i];
      end
      q[8] = ~use_xnor;
      qm_d  = q;
      n1q_d = ones8(q[7:0]);
   end

   logic [8:0] s1_qm;
   logic [3:0] s1_n1;
   logic       s1_de;
   logic       s1_c0;
   logic       s1_c1;

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         s1_qm <= 9'h000;
         s1_n1 <= 4'd0;
         s1_de <= 1'b0;
         s1_c0 <= 1'b0;
         s1_c1 <= 1'b0;
      end else begin
         s1_qm <= qm_d;
         s1_n1 <= n1q_d;
         s1_de <= in_de;
         s1_c0 <= in_c0;
         s1_c1 <= in_c1;
      end
   end

   // stage 2: DC balance
   logic signed [4:0] cnt_q;
   logic signed [4:0] cnt_d;
   logic [9:0]        tmds_q;
   logic [9:0]        tmds_d;

   always_comb begin
      logic signed [4:0] diff;
      logic signed [4:0] two_qm;
      logic signed [4:0] two_nqm;
      logic              case_a;
      logic              case_b;
      logic              qm8;
      qm8 = s1_qm[8];
      // diff = n1q - n0q = 2*n1q - 8
      diff = $signed({s1_n1, 1'b0} - 5'd8);
      two_qm  = $signed({3'b000, qm8, 1'b0});
      two_nqm = $signed({3'b000, ~qm8, 1'b0});
      case_a = (cnt_q == 5'sd0) ||
               (diff == 5'sd0);
      case_b = ((cnt_q > 5'sd0) && (diff > 5'sd0)) ||
               ((cnt_q < 5'sd0) && (diff < 5'sd0));
      tmds_d = TOK_00;
      cnt_d  = 5'sd0;
      if (!s1_de) begin
         unique case ({s1_c1, s1_c0})
            2'b00: tmds_d = TOK_00;
            2'b01: tmds_d = TOK_01;
            2'b10: tmds_d = TOK_10;
            2'b11: tmds_d = TOK_11;
            default: tmds_d = TOK_00;
         endcase
      end else begin
         unique case (1'b1)
            case_a: begin
               if (qm8) begin
                  tmds_d = {2'b01, s1_qm[7:0]};
                  cnt_d  = cnt_q + diff;
               end else begin
                  tmds_d = {2'b10, ~s1_qm[7:0]};
                  cnt_d  = cnt_q - diff;
               end
            end
            case_b: begin
               tmds_d = {1'b1, qm8, ~s1_qm[7:0]};
               cnt_d  = cnt_q + two_qm - diff;
            end
            default: begin
               tmds_d = {1'b0, qm8, s1_qm[7:0]};
               cnt_d  = cnt_q + diff - two_nqm;
            end
         endcase
      end
   end

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         tmds_q <= TOK_00;
         cnt_q  <= 5'sd0;
      end else begin
         tmds_q <= tmds_d;
         cnt_q  <= cnt_d;
      end
   end

   assign link.tmds = tmds_q;

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Scoreboard bench for dvi_tmds_encoder.
// Reference model runs at drive time; results checked LAT cycles later.
module tb_dvi_tmds_encoder;

   localparam bit REG_IN = 1'b0;
   localparam int LAT    = REG_IN ? 3 : 2;

   typedef struct {
      logic [9:0] tmds;
      int         cnt;
      logic       de;
      logic [7:0] data;
   } exp_t;

   logic pixel_clk = 1'b0;
   logic reset     = 1'b1;

   dvi_tmds_encoder_if link();

   dvi_tmds_encoder #(
      .REGISTER_INPUTS(REG_IN)
   ) dut (
      .pixel_clk(pixel_clk),
      .reset    (reset),
      .link     (link)
   );

   always #5 pixel_clk = ~pixel_clk;

   exp_t sbq[$];
   int   m_cnt = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(
      input string tag,
      input int    got,
      input int    exp
   );
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, got, got, exp, exp);
      end
   endtask

   function automatic logic [9:0] ref_enc(
      input logic [7:0] d,
      input logic       de,
      input logic       c0,
      input logic       c1,
      inout int         cnt
   );
      int         n1;
      int         n1q;
      int         n0q;
      logic [8:0] q;
      logic [9:0] r;
      if (!de) begin
         cnt = 0;
         case ({c1, c0})
            2'b00:   r = 10'h354;
            2'b01:   r = 10'h0AB;
            2'b10:   r = 10'h154;
            default: r = 10'h2AB;
         endcase
         return r;
      end
      n1 = 0;
      for (int i = 0; i < 8; i++) n1 += int'(d[i]);
      q = '0;
      q[0] = d[0];
      if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
         for (int i = 1; i < 8; i++) q[i] = ~(q[i-1] ^ d[i]);
         q[8] = 1'b0;
      end else begin
         for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
         q[8] = 1'b1;
      end
      n1q = 0;
      for (int i = 0; i < 8; i++) n1q += int'(q[i]);
      n0q = 8 - n1q;
      if (cnt == 0 || n1q == n0q) begin
         r = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
         cnt += q[8] ? (n1q - n0q) : (n0q - n1q);
      end else if ((cnt > 0 && n1q > n0q) ||
                   (cnt < 0 && n0q > n1q)) begin
         r = {1'b1, q[8], ~q[7:0]};
         cnt += 2 * int'(q[8]) + (n0q - n1q);
      end else begin
         r = {1'b0, q[8], q[7:0]};
         cnt += (n1q - n0q) - 2 * (q[8] ? 0 : 1);
      end
      return r;
   endfunction

   function automatic logic [7:0] dec(input logic [9:0] s);
      logic [7:0] q;
      logic [7:0] d;
      q = s[9] ? ~s[7:0] : s[7:0];
      d[0] = q[0];
      for (int i = 1; i < 8; i++)
         d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
      return d;
   endfunction

   task automatic drive(
      input logic [7:0] d,
      input logic       de,
      input logic       c0,
      input logic       c1
   );
      exp_t e;
      e.tmds = ref_enc(d, de, c0, c1, m_cnt);
      e.cnt  = m_cnt;
      e.de   = de;
      e.data = d;
      sbq.push_back(e);
      link.data = d;
      link.de   = de;
      link.c0   = c0;
      link.c1   = c1;
   endtask

   task automatic step();
      exp_t e;
      int   c;
      @(posedge pixel_clk);
      #1;
      if (sbq.size() == 0) begin
         chk("sb_empty", 0, 1);
      end else begin
         e = sbq.pop_front();
         c = int'(dut.cnt_q);
         chk("tmds", int'(link.tmds), int'(e.tmds));
         chk("cnt", c, e.cnt);
         chk("cnt_bound", int'(c <= 10 && c >= -10), 1);
         if (e.de)
            chk("decode", int'(dec(link.tmds)), int'(e.data));
      end
   endtask

   task automatic sb_reset();
      exp_t e;
      sbq.delete();
      m_cnt  = 0;
      e.tmds = 10'h354;
      e.cnt  = 0;
      e.de   = 1'b0;
      e.data = 8'h00;
      for (int i = 0; i < LAT - 1; i++) sbq.push_back(e);
   endtask

   task automatic cyc(
      input logic [7:0] d,
      input logic       de,
      input logic       c0,
      input logic       c1
   );
      drive(d, de, c0, c1);
      step();
   endtask

   initial begin
      link.data = 8'h00;
      link.de   = 1'b0;
      link.c0   = 1'b0;
      link.c1   = 1'b0;
      repeat (3) @(posedge pixel_clk);
      #1;
      chk("rst_tmds", int'(link.tmds), 10'h354);
      chk("rst_cnt", int'(dut.cnt_q), 0);
      @(negedge pixel_clk);
      reset = 1'b0;
      sb_reset();

      // control tokens
      for (int k = 0; k < 4; k++)
         cyc(8'h00, 1'b0, k[0], k[1]);
      for (int k = 3; k >= 0; k--)
         cyc(8'h5A, 1'b0, k[0], k[1]);
      repeat (2) cyc(8'h00, 1'b0, 1'b0, 1'b0);

      // disparity alternation on zeros
      repeat (9) cyc(8'h00, 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(8'h00, 1'b0, 1'b1, 1'b0);

      // XNOR path single pixel
      cyc(8'hFF, 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(8'h00, 1'b0, 1'b0, 1'b0);

      // async reset mid-line
      for (int k = 0; k < 5; k++)
         cyc(8'($urandom), 1'b1, 1'b0, 1'b0);
      @(negedge pixel_clk);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_async_tmds", int'(link.tmds), 10'h354);
      chk("rst_async_cnt", int'(dut.cnt_q), 0);
      link.data = 8'h00;
      link.de   = 1'b0;
      link.c0   = 1'b0;
      link.c1   = 1'b0;
      @(posedge pixel_clk);
      #1;
      chk("rst_hold_tmds", int'(link.tmds), 10'h354);
      @(negedge pixel_clk);
      reset = 1'b0;
      sb_reset();
      repeat (4) cyc(8'h00, 1'b0, 1'b0, 1'b0);

      // random traffic with blanking gaps
      for (int k = 0; k < 10000; k++) begin
         logic de;
         de = ($urandom_range(0, 7) != 0);
         cyc(8'($urandom), de,
             1'($urandom), 1'($urandom));
      end
      repeat (LAT) cyc(8'h00, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
